// File: rtl/bank_req_router_pkg.sv
// Shared state type, bank constants and helpers
// for the bank request router.
package bank_req_router_pkg;

  localparam int NUM_BANKS = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    EMPTY,
    HOLD
  } state_t;

  function automatic logic [SEL_W-1:0] bank_idx(
    input logic [NUM_BANKS-1:0] oh
  );
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (oh[i]) idx = SEL_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/bank_req_router_rd_tag_pipe.sv
// Read-tag shift pipeline: a tag pushed on one edge
// reaches the tail after RD_LATENCY edges.
module rd_tag_pipe #(
  parameter int RD_LATENCY = 2,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] tag,
  output logic             valid,
  output logic [TAG_W-1:0] tag_out
);

  logic [RD_LATENCY-1:0] vld;
  logic [TAG_W-1:0]      tags [RD_LATENCY];

  // idle slots carry the previous tag so the mux select stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++)
        tags[i] <= '0;
    end else begin
      vld[0]  <= push;
      tags[0] <= push ? tag : tags[0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i]  <= vld[i-1];
        tags[i] <= tags[i-1];
      end
    end
  end

  assign valid   = vld[RD_LATENCY-1];
  assign tag_out = tags[RD_LATENCY-1];

endmodule

// File: rtl/bank_req_router.sv
// Single-entry request router: holds one request and
// issues it to its bank once that bank is not busy.
module bank_req_router
  import bank_req_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_1 = 5,
  parameter int ADDR_2 = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_wr_en,
  input  logic [ADDR_1-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [NUM_BANKS-1:0]  i_bank_busy,
  output logic [NUM_BANKS-1:0]  o_bank_en,
  output logic                  o_bank_we,
  output logic [ADDR_2-2:0]     o_bank_addr,
  output logic [DATA_WIDTH-1:0] o_bank_wdata,
  output logic [SEL_W-1:0]      o_rd_sel,
  output logic                  o_rd_valid
);

  state_t state, state_nx;

  logic                  hold_we;
  logic [SEL_W-1:0]      hold_bank;
  logic [ADDR_2-2:0]     hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic                  issue;
  logic                  accept;

  always_comb begin
    issue    = (state == HOLD) && !i_bank_busy[hold_bank];
    o_ready  = (state == EMPTY) || issue;
    accept   = i_valid && o_ready;
    state_nx = state;
    unique case (state)
      EMPTY: if (accept) state_nx = HOLD;
      HOLD:  if (issue && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= EMPTY;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_we    <= 1'b0;
      hold_bank  <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (accept) begin
      hold_we    <= i_wr_en;
      hold_bank  <= i_addr[ADDR_1-1:ADDR_2-1];
      hold_addr  <= i_addr[ADDR_2-2:0];
      hold_wdata <= i_wdata;
    end
  end

  // strobes last one cycle; address and data persist
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bank_en    <= '0;
      o_bank_we    <= 1'b0;
      o_bank_addr  <= '0;
      o_bank_wdata <= '0;
    end else begin
      o_bank_en <= issue ? (NUM_BANKS'(1) << hold_bank) : '0;
      o_bank_we <= issue && hold_we;
      if (issue) begin
        o_bank_addr  <= hold_addr;
        o_bank_wdata <= hold_wdata;
      end
    end
  end

  logic rd_push;

  assign rd_push = (|o_bank_en) && !o_bank_we;

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY),
    .TAG_W     (SEL_W)
  ) u_rd_tag_pipe (
    .clk    (i_clk),
    .rst    (i_rst),
    .push   (rd_push),
    .tag    (bank_idx(o_bank_en)),
    .valid  (o_rd_valid),
    .tag_out(o_rd_sel)
  );

endmodule

// File: tb/tb_bank_req_router.sv
// Scoreboard bench for bank_req_router: driver queues
// expected bank strobes and read returns, monitor checks.
module tb_bank_req_router;

  localparam int LAT = 2;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic       i_wr_en;
  logic [4:0] i_addr;
  logic [7:0] i_wdata;
  logic [3:0] i_bank_busy;
  logic [3:0] o_bank_en;
  logic       o_bank_we;
  logic [2:0] o_bank_addr;
  logic [7:0] o_bank_wdata;
  logic [1:0] o_rd_sel;
  logic       o_rd_valid;

  bank_req_router #(
    .DATA_WIDTH(8),
    .ADDR_1    (5),
    .ADDR_2    (4),
    .RD_LATENCY(LAT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_wr_en     (i_wr_en),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_bank_busy (i_bank_busy),
    .o_bank_en   (o_bank_en),
    .o_bank_we   (o_bank_we),
    .o_bank_addr (o_bank_addr),
    .o_bank_wdata(o_bank_wdata),
    .o_rd_sel    (o_rd_sel),
    .o_rd_valid  (o_rd_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
  } bank_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
  } rd_exp_t;

  bank_exp_t bq[$];
  rd_exp_t   rq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compare every DUT strobe against the scoreboard
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_bank_en != 4'b0000) begin
        if (bq.size() == 0) begin
          chk("bank_unexpected", {28'd0, o_bank_en}, 32'd0);
        end else begin
          bank_exp_t e;
          e = bq.pop_front();
          chk("bank_cyc", cyc, e.cyc);
          chk("bank_en", {28'd0, o_bank_en}, {28'd0, e.en});
          chk("bank_we", {31'd0, o_bank_we}, {31'd0, e.we});
          chk("bank_addr", {29'd0, o_bank_addr}, {29'd0, e.addr});
          chk("bank_wdata", {24'd0, o_bank_wdata}, {24'd0, e.wdata});
        end
      end else begin
        chk("idle_we", {31'd0, o_bank_we}, 32'd0);
      end
      if (o_rd_valid) begin
        if (rq.size() == 0) begin
          chk("rd_unexpected", {31'd0, o_rd_valid}, 32'd0);
        end else begin
          rd_exp_t r;
          r = rq.pop_front();
          chk("rd_cyc", cyc, r.cyc);
          chk("rd_sel", {30'd0, o_rd_sel}, {30'd0, r.sel});
        end
      end
    end
  end

  // called just after a rising edge; returns the accept edge count
  task automatic send(input logic we, input logic [4:0] addr,
                      input logic [7:0] wd, input logic [3:0] en,
                      input logic [2:0] la, input logic [1:0] sel,
                      input int stall, output int k);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_wr_en = we;
    i_addr  = addr;
    i_wdata = wd;
    #1;
    while (!o_ready && n < 50) begin
      @(posedge i_clk);
      #2;
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
      k = -1;
    end else begin
      @(posedge i_clk);
      #1;
      k = cyc;
      i_valid = 1'b0;
      bq.push_back('{k + 1 + stall, en, we, la, wd});
      if (!we) rq.push_back('{k + 1 + stall + LAT, sel});
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    chk({tag, "_en"}, {28'd0, o_bank_en}, 32'd0);
    chk({tag, "_we"}, {31'd0, o_bank_we}, 32'd0);
    chk({tag, "_addr"}, {29'd0, o_bank_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, o_bank_wdata}, 32'd0);
    chk({tag, "_rd_sel"}, {30'd0, o_rd_sel}, 32'd0);
    chk({tag, "_rd_valid"}, {31'd0, o_rd_valid}, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int c0;
    i_rst       = 1'b1;
    i_valid     = 1'b0;
    i_wr_en     = 1'b0;
    i_addr      = '0;
    i_wdata     = '0;
    i_bank_busy = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_zero_outs("reset");
    i_rst = 1'b0;
    c0 = cyc;

    // single read to 0x12: bank 2, local 2
    send(1'b0, 5'h12, 8'h00, 4'b0100, 3'd2, 2'd2, 0, k);
    chk("first_accept", k, c0 + 1);
    repeat (5) @(posedge i_clk);
    #1;

    // back-to-back reads across all banks
    send(1'b0, 5'h00, 8'h00, 4'b0001, 3'd0, 2'd0, 0, k);
    send(1'b0, 5'h08, 8'h00, 4'b0010, 3'd0, 2'd1, 0, k);
    send(1'b0, 5'h10, 8'h00, 4'b0100, 3'd0, 2'd2, 0, k);
    send(1'b0, 5'h18, 8'h00, 4'b1000, 3'd0, 2'd3, 0, k);
    repeat (5) @(posedge i_clk);
    #1;

    // interleaved writes and reads
    send(1'b1, 5'h05, 8'h11, 4'b0001, 3'd5, 2'd0, 0, k);
    send(1'b0, 5'h0E, 8'h22, 4'b0010, 3'd6, 2'd1, 0, k);
    send(1'b1, 5'h13, 8'h33, 4'b0100, 3'd3, 2'd2, 0, k);
    send(1'b0, 5'h19, 8'h44, 4'b1000, 3'd1, 2'd3, 0, k);
    repeat (5) @(posedge i_clk);
    #1;

    // busy on other banks must not stall a bank-2 read
    i_bank_busy = 4'b1011;
    send(1'b0, 5'h15, 8'h5A, 4'b0100, 3'd5, 2'd2, 0, k);
    repeat (4) @(posedge i_clk);
    #1;
    i_bank_busy = 4'b0000;

    // write to bank 1 while bank 1 is busy for 3 cycles
    i_bank_busy = 4'b0010;
    send(1'b1, 5'h08, 8'h3C, 4'b0010, 3'd0, 2'd1, 3, k);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_ready", {31'd0, o_ready}, 32'd0);
      @(posedge i_clk);
      #1;
    end
    i_bank_busy = 4'b0000;
    repeat (5) @(posedge i_clk);
    #1;

    // top address wraps to bank 3, local 7
    send(1'b1, 5'h1F, 8'hA5, 4'b1000, 3'd7, 2'd3, 0, k);
    repeat (5) @(posedge i_clk);
    #1;

    // reset while a read is in flight drops its return
    send(1'b0, 5'h10, 8'h77, 4'b0100, 3'd0, 2'd2, 0, k);
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    rq.delete();
    #1;
    chk_zero_outs("midreset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (8) @(posedge i_clk);
    #1;

    // normal operation resumes after reset
    send(1'b0, 5'h0B, 8'h00, 4'b0010, 3'd3, 2'd1, 0, k);
    repeat (6) @(posedge i_clk);
    #1;

    chk("bank_q_empty", bq.size(), 32'd0);
    chk("rd_q_empty", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
